// File: rtl/relay_station_chain.sv
// ---------------------------------------------------------------------------
// relay_station_chain
//
// A chain of STAGES valid/ready register slices used to break long routing
// paths between two valid/ready endpoints. It never drops, duplicates or
// reorders words, and it sustains one word per cycle in every mode.
//
// MODE selects the slice flavour used for every stage:
//   0 = FWD  : data/valid registered, ready combinational (1 entry, 1 cycle)
//   1 = BWD  : ready registered, data/valid pass through, skid entry (0 cycle)
//   2 = FULL : both directions registered, main + skid entry (1 cycle)
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous reset, active-high; discards all held words
//   valid_s    in   upstream valid
//   ready_s    out  upstream ready (held low while rst is high)
//   data_s     in   upstream payload
//   valid_m    out  downstream valid (held low while rst is high)
//   ready_m    in   downstream ready
//   data_m     out  downstream payload, don't-care while valid_m is low
//   occupancy  out  number of words currently held (registered)
// ---------------------------------------------------------------------------
module relay_station_chain #(
   parameter int DATA_WIDTH = 8,
   parameter int STAGES     = 1,
   parameter int MODE       = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  valid_s,
   output logic                                  ready_s,
   input  logic [DATA_WIDTH-1:0]                 data_s,
   output logic                                  valid_m,
   input  logic                                  ready_m,
   output logic [DATA_WIDTH-1:0]                 data_m,
   output logic [$clog2(2*STAGES+1)-1:0]         occupancy
);

   localparam int OW = $clog2(2*STAGES+1);

   localparam int MODE_FWD = 0;
   localparam int MODE_BWD = 1;

   // Per-stage count of entries that will be valid after the coming edge,
   // two bits per stage (a FULL slice can hold two words).
   logic [2*STAGES-1:0] cnt_all;

   logic [OW-1:0] occupancy_d;
   logic [OW-1:0] occupancy_q;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // Slave side of this slice.
      logic                  in_valid;
      logic [DATA_WIDTH-1:0] in_data;
      logic                  up_ready;
      // Master side of this slice.
      logic                  dn_valid;
      logic [DATA_WIDTH-1:0] dn_data;
      logic                  out_ready;

      // The upstream valid is masked during reset so a BWD chain, whose
      // valid passes straight through, cannot present a word downstream.
      if (gi == 0) begin : g_head
         assign in_valid = valid_s & ~rst;
         assign in_data  = data_s;
      end else begin : g_link
         assign in_valid = g_stage[gi-1].dn_valid;
         assign in_data  = g_stage[gi-1].dn_data;
      end

      if (gi == STAGES-1) begin : g_tail
         assign out_ready = ready_m;
      end else begin : g_next
         assign out_ready = g_stage[gi+1].up_ready;
      end

      if (MODE == MODE_FWD) begin : g_fwd
         logic                  v_q;
         logic                  v_d;
         logic [DATA_WIDTH-1:0] data_q;
         logic [DATA_WIDTH-1:0] data_d;

         // The slot can take a word when it is empty or being emptied now;
         // this ready ripples combinationally through the whole chain.
         assign up_ready = ~v_q | out_ready;

         always_comb begin
            v_d    = v_q;
            data_d = data_q;
            if (in_valid && up_ready) begin
               v_d    = 1'b1;
               data_d = in_data;
            end else if (out_ready) begin
               v_d = 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               v_q <= 1'b0;
            end else begin
               v_q <= v_d;
            end
         end

         always_ff @(posedge clk) begin
            data_q <= data_d;
         end

         assign dn_valid = v_q;
         assign dn_data  = data_q;
         assign cnt_all[2*gi +: 2] = {1'b0, v_d};
      end else if (MODE == MODE_BWD) begin : g_bwd
         logic                  skid_v_q;
         logic                  skid_v_d;
         logic [DATA_WIDTH-1:0] skid_data_q;
         logic [DATA_WIDTH-1:0] skid_data_d;

         // Ready comes straight from a flop, cutting the backward path.
         assign up_ready = ~skid_v_q;

         always_comb begin
            skid_v_d    = skid_v_q;
            skid_data_d = skid_data_q;
            // A word accepted upstream while downstream refuses it must be
            // parked, since upstream already considers it delivered.
            if (in_valid && up_ready && !out_ready) begin
               skid_v_d    = 1'b1;
               skid_data_d = in_data;
            end else if (out_ready) begin
               skid_v_d = 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               skid_v_q <= 1'b0;
            end else begin
               skid_v_q <= skid_v_d;
            end
         end

         always_ff @(posedge clk) begin
            skid_data_q <= skid_data_d;
         end

         // The parked word always has priority: it is older than anything
         // upstream, and upstream is stalled while it is held.
         assign dn_valid = skid_v_q | in_valid;
         assign dn_data  = skid_v_q ? skid_data_q : in_data;
         assign cnt_all[2*gi +: 2] = {1'b0, skid_v_d};
      end else begin : g_full
         logic                  m_v_q;
         logic                  m_v_d;
         logic [DATA_WIDTH-1:0] m_data_q;
         logic [DATA_WIDTH-1:0] m_data_d;
         logic                  s_v_q;
         logic                  s_v_d;
         logic [DATA_WIDTH-1:0] s_data_q;
         logic [DATA_WIDTH-1:0] s_data_d;
         logic                  drain;
         logic                  fill;

         assign up_ready = ~s_v_q;
         assign drain    = m_v_q & out_ready;
         assign fill     = in_valid & up_ready;

         // When the skid entry is occupied the slice refuses input, so a
         // drain never coincides with a fill while both entries are full.
         always_comb begin
            m_v_d    = m_v_q;
            m_data_d = m_data_q;
            s_v_d    = s_v_q;
            s_data_d = s_data_q;
            if (drain) begin
               if (s_v_q) begin
                  m_data_d = s_data_q;
                  s_v_d    = 1'b0;
               end else if (fill) begin
                  m_data_d = in_data;
               end else begin
                  m_v_d = 1'b0;
               end
            end else if (fill) begin
               if (!m_v_q) begin
                  m_v_d    = 1'b1;
                  m_data_d = in_data;
               end else begin
                  s_v_d    = 1'b1;
                  s_data_d = in_data;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               m_v_q <= 1'b0;
               s_v_q <= 1'b0;
            end else begin
               m_v_q <= m_v_d;
               s_v_q <= s_v_d;
            end
         end

         always_ff @(posedge clk) begin
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
         end

         assign dn_valid = m_v_q;
         assign dn_data  = m_data_q;
         assign cnt_all[2*gi +: 2] = {1'b0, m_v_d} + {1'b0, s_v_d};
      end
   end

   // Summing the next-state valids keeps the registered occupancy equal to
   // the number of valid entries held in the slices at any given cycle.
   always_comb begin
      occupancy_d = '0;
      for (int i = 0; i < STAGES; i++) begin
         occupancy_d = occupancy_d + OW'(cnt_all[2*i +: 2]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occupancy_q <= '0;
      end else begin
         occupancy_q <= occupancy_d;
      end
   end

   assign ready_s   = g_stage[0].up_ready & ~rst;
   assign valid_m   = g_stage[STAGES-1].dn_valid & ~rst;
   assign data_m    = g_stage[STAGES-1].dn_data;
   assign occupancy = occupancy_q;

endmodule

// File: tb/tb_relay_station_chain.sv
// ---------------------------------------------------------------------------
// tb_relay_station_chain
//
// Eight chains in different MODE/STAGES configurations run side by side on
// one clock and one reset. A reference model tracks, per chain, the words
// accepted but not yet delivered as a simple FIFO; every cycle it checks
// delivery order, output stability under back-pressure, reset behaviour and
// that the reported occupancy equals the number of words inside. Directed
// sequences pin latency, capacity and skid behaviour with literal values.
//
// Instances: 0 FULL/3, 1 FULL/2, 2 BWD/1, 3 FWD/1, 4 FWD/4, 5 BWD/4,
//            6 FULL/1, 7 FULL/4
// ---------------------------------------------------------------------------
module tb_relay_station_chain;

   localparam int NI     = 8;
   localparam int N_RAND = 10000;
   localparam int SB_N   = 16;

   function automatic int cfg_stages(input int i);
      case (i)
         0:       return 3;
         1:       return 2;
         4, 5, 7: return 4;
         default: return 1;
      endcase
   endfunction

   function automatic int cfg_mode(input int i);
      case (i)
         2, 5:    return 1;
         3, 4:    return 0;
         default: return 2;
      endcase
   endfunction

   logic              clk;
   logic              rst;
   logic              valid_s_a [NI];
   logic [7:0]        data_s_a  [NI];
   logic              ready_m_a [NI];
   logic [NI-1:0]     ready_s_v;
   logic [NI-1:0]     valid_m_v;
   logic [NI*8-1:0]   data_m_v;
   logic [NI*8-1:0]   occ_v;

   int n_vec;
   int n_err;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int ST = cfg_stages(gi);
      localparam int MD = cfg_mode(gi);
      logic                          rs;
      logic                          vm;
      logic [7:0]                    dm;
      logic [$clog2(2*ST+1)-1:0]     oc;

      relay_station_chain #(.DATA_WIDTH(8), .STAGES(ST), .MODE(MD)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .valid_s   (valid_s_a[gi]),
         .ready_s   (rs),
         .data_s    (data_s_a[gi]),
         .valid_m   (vm),
         .ready_m   (ready_m_a[gi]),
         .data_m    (dm),
         .occupancy (oc)
      );

      assign ready_s_v[gi]        = rs;
      assign valid_m_v[gi]        = vm;
      assign data_m_v[gi*8 +: 8]  = dm;
      assign occ_v[gi*8 +: 8]     = 8'(oc);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] dm_of(input int i);
      return data_m_v[i*8 +: 8];
   endfunction

   function automatic logic [31:0] occ_of(input int i);
      return 32'(occ_v[i*8 +: 8]);
   endfunction

   task automatic check(input int inst, input string name,
                        input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s inst%0d t=%0t: got 0x%0h, required 0x%0h",
                  name, inst, $time, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model and per-cycle compare ----------------
   logic [7:0] sb_mem  [NI][SB_N];
   int         sb_rd   [NI];
   int         sb_wr   [NI];
   logic       hold    [NI];
   logic [7:0] hold_dat[NI];
   logic       known;

   function automatic int sb_size(input int i);
      return sb_wr[i] - sb_rd[i];
   endfunction

   initial begin
      known = 1'b0;
      for (int i = 0; i < NI; i++) begin
         sb_rd[i]    = 0;
         sb_wr[i]    = 0;
         hold[i]     = 1'b0;
         hold_dat[i] = 8'h00;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (known) check(i, "occupancy", occ_of(i), 32'(sb_size(i)));
            if (rst) begin
               check(i, "rst_ready_s", 32'(ready_s_v[i]), 32'd0);
               check(i, "rst_valid_m", 32'(valid_m_v[i]), 32'd0);
               sb_rd[i] = sb_wr[i];
               hold[i]  = 1'b0;
            end else begin
               if (hold[i]) begin
                  check(i, "stall_valid_m", 32'(valid_m_v[i]), 32'd1);
                  check(i, "stall_data_m", 32'(dm_of(i)), 32'(hold_dat[i]));
               end
               if (valid_s_a[i] && ready_s_v[i]) begin
                  sb_mem[i][sb_wr[i] % SB_N] = data_s_a[i];
                  sb_wr[i]++;
               end
               if (valid_m_v[i] && ready_m_a[i]) begin
                  check(i, "deliver_nonempty", 32'(sb_size(i) > 0), 32'd1);
                  if (sb_size(i) > 0) begin
                     check(i, "order_data_m", 32'(dm_of(i)),
                           32'(sb_mem[i][sb_rd[i] % SB_N]));
                     sb_rd[i]++;
                  end
               end
               hold[i]     = valid_m_v[i] & ~ready_m_a[i];
               hold_dat[i] = dm_of(i);
            end
         end
         if (rst) known = 1'b1;
      end
   end

   // ---------------- directed and random stimulus ----------------
   initial begin
      int         acc;
      int         got;
      int         cyc;
      logic [7:0] w;
      int         sent     [NI];
      logic [7:0] word     [NI];
      logic       acc_last [NI];
      logic       done;

      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      for (int i = 0; i < NI; i++) begin
         valid_s_a[i] = 1'b1;
         data_s_a[i]  = 8'h00;
         ready_m_a[i] = 1'b1;
      end

      // T1: three reset cycles with upstream offering data.
      for (int c = 0; c < 3; c++) begin
         #2;
         check(0, "t1_ready_s", 32'(ready_s_v[0]), 32'd0);
         check(0, "t1_valid_m", 32'(valid_m_v[0]), 32'd0);
         check(2, "t1_valid_m_bwd", 32'(valid_m_v[2]), 32'd0);
         if (c > 0) check(0, "t1_occupancy", occ_of(0), 32'd0);
         step();
      end
      rst = 1'b0;
      for (int i = 0; i < NI; i++) valid_s_a[i] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check(0, "t1_no_word", 32'(valid_m_v[0]), 32'd0);
         check(0, "t1_occ_after", occ_of(0), 32'd0);
         step();
      end

      // T2: FULL x3, 32 back-to-back words, 3-cycle latency, 1 word/cycle.
      for (int c = 0; c < 38; c++) begin
         valid_s_a[0] = (c < 32);
         data_s_a[0]  = 8'(c + 1);
         #1;
         if (c < 32) check(0, "t2_ready_s", 32'(ready_s_v[0]), 32'd1);
         if (c >= 3 && c < 35) begin
            check(0, "t2_valid_m", 32'(valid_m_v[0]), 32'd1);
            check(0, "t2_data_m", 32'(dm_of(0)), 32'(c - 2));
         end else begin
            check(0, "t2_idle_valid_m", 32'(valid_m_v[0]), 32'd0);
         end
         step();
      end
      valid_s_a[0] = 1'b0;

      // T3: FULL x2 stalled downstream holds exactly four words.
      ready_m_a[1] = 1'b0;
      w   = 8'hA0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         valid_s_a[1] = 1'b1;
         data_s_a[1]  = w;
         #1;
         if (ready_s_v[1]) begin
            acc++;
            w++;
         end
         step();
      end
      valid_s_a[1] = 1'b0;
      #1;
      check(1, "t3_accepted", 32'(acc), 32'd4);
      check(1, "t3_ready_s_full", 32'(ready_s_v[1]), 32'd0);
      check(1, "t3_occupancy_full", occ_of(1), 32'd4);
      ready_m_a[1] = 1'b1;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (valid_m_v[1]) begin
            check(1, "t3_drain_data", 32'(dm_of(1)), 32'(8'hA0 + got));
            got++;
         end
         step();
      end
      #1;
      check(1, "t3_drained", 32'(got), 32'd4);
      check(1, "t3_occupancy_empty", occ_of(1), 32'd0);
      step();

      // T4: BWD x1, downstream stalls one cycle; the skid holds one word.
      w = 8'h50;
      for (int c = 0; c < 10; c++) begin
         ready_m_a[2] = (c != 3);
         valid_s_a[2] = 1'b1;
         data_s_a[2]  = w;
         #1;
         check(2, "t4_valid_m", 32'(valid_m_v[2]), 32'd1);
         check(2, "t4_occupancy", occ_of(2), (c == 4) ? 32'd1 : 32'd0);
         if (c == 4) begin
            check(2, "t4_ready_s_skid", 32'(ready_s_v[2]), 32'd0);
            check(2, "t4_skid_data", 32'(dm_of(2)), 32'h53);
         end else begin
            check(2, "t4_ready_s", 32'(ready_s_v[2]), 32'd1);
            check(2, "t4_passthrough", 32'(dm_of(2)), 32'(w));
         end
         if (ready_s_v[2]) w++;
         step();
      end
      valid_s_a[2] = 1'b0;
      ready_m_a[2] = 1'b1;
      step();

      // T6: FULL x2 holding three words, one-cycle reset pulse.
      ready_m_a[1] = 1'b0;
      w   = 8'hE0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         valid_s_a[1] = (acc < 3);
         data_s_a[1]  = w;
         #1;
         if (valid_s_a[1] && ready_s_v[1]) begin
            acc++;
            w++;
         end
         step();
      end
      valid_s_a[1] = 1'b0;
      #1;
      check(1, "t6_loaded", occ_of(1), 32'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check(1, "t6_occ_cleared", occ_of(1), 32'd0);
      check(1, "t6_valid_cleared", 32'(valid_m_v[1]), 32'd0);
      ready_m_a[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         #1;
         check(1, "t6_no_stale_word", 32'(valid_m_v[1]), 32'd0);
      end
      step();

      // T5: random valid_s/ready_m on every chain, 10k words each.
      for (int i = 0; i < NI; i++) begin
         sent[i]      = 0;
         word[i]      = 8'(i * 16);
         acc_last[i]  = 1'b0;
         valid_s_a[i] = 1'b0;
      end
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 60000) begin
         for (int i = 0; i < NI; i++) begin
            if (acc_last[i]) begin
               sent[i]++;
               word[i]++;
            end
            // A word offered but not yet taken must stay on the bus.
            if (!(valid_s_a[i] && !acc_last[i])) begin
               valid_s_a[i] = (sent[i] < N_RAND) && ($urandom_range(1) == 1);
               data_s_a[i]  = word[i];
            end
            ready_m_a[i] = ($urandom_range(1) == 1);
         end
         #1;
         done = 1'b1;
         for (int i = 0; i < NI; i++) begin
            acc_last[i] = valid_s_a[i] & ready_s_v[i];
            if (sent[i] < N_RAND || sb_size(i) != 0) done = 1'b0;
         end
         step();
         cyc++;
      end
      check(0, "t5_complete", 32'(done), 32'd1);
      for (int i = 0; i < NI; i++) check(i, "t5_words_sent", 32'(sent[i]), 32'(N_RAND));

      for (int i = 0; i < NI; i++) begin
         valid_s_a[i] = 1'b0;
         ready_m_a[i] = 1'b1;
      end
      repeat (10) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
